// File: rtl/mlp_pkg.sv
// Shared types and sizing helpers for the MLP layer sequencer and its layer bus.
package mlp_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_RELU  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Activation-to-MAC alignment delay; equals the weight-memory read latency.
  localparam int ISSUE_LAT = 1;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int nr_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mlp_layer_ctrl_if.sv
// Control/data bus from the sequencer (master) to the MLP layer datapath (slave).
interface mlp_layer_ctrl_if #(
  parameter int IDX_W     = 2,
  parameter int NR_W      = 3,
  parameter int IN_WIDTH  = 16,
  parameter int WGT_WIDTH = 16
);
  // No back-pressure: layer_start/layer_valid each qualify layer_input_value for
  // exactly one cycle and the layer must consume it; layer_wr_en qualifies the
  // row/col/weight triple for the edge that ends that cycle.
  logic                        layer_wr_en;
  logic [NR_W-1:0]             layer_wr_row;
  logic [IDX_W-1:0]            layer_wr_col;
  logic [WGT_WIDTH-1:0]        layer_wr_weight;
  logic [IDX_W-1:0]            layer_input_index;
  logic signed [IN_WIDTH-1:0]  layer_input_value;
  logic                        layer_start;
  logic                        layer_valid;
  logic                        layer_relu_en;

  modport master (
    output layer_wr_en, layer_wr_row, layer_wr_col, layer_wr_weight,
    output layer_input_index, layer_input_value,
    output layer_start, layer_valid, layer_relu_en
  );

  modport slave (
    input layer_wr_en, layer_wr_row, layer_wr_col, layer_wr_weight,
    input layer_input_index, layer_input_value,
    input layer_start, layer_valid, layer_relu_en
  );
endinterface

// File: rtl/mlp_layer_ctrl.sv
// Sequencer for one fully-connected layer: streams activations, drives MAC
// strobes and the ReLU capture, and gates host weight writes while running.
module mlp_layer_ctrl
  import mlp_pkg::*;
#(
  parameter int N_INPUTS  = 4,
  parameter int N_NEURONS = 8,
  parameter int IN_WIDTH  = 16,
  parameter int WGT_WIDTH = 16,
  localparam int IDX_W    = idx_w(N_INPUTS),
  localparam int NR_W     = nr_w(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     in_addr,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 cfg_wr_en,
  input  logic [NR_W-1:0]      cfg_wr_row,
  input  logic [IDX_W-1:0]     cfg_wr_col,
  input  logic [WGT_WIDTH-1:0] cfg_wr_weight,
  output logic                 cfg_wr_rej,
  mlp_layer_ctrl_if.master     lyr,
  output state_t               dbg_state
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

  state_t           state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic             pv, pfirst;
  logic             issuing, idle;

  assign issuing = (state == S_ISSUE);
  assign idle    = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      pv         <= 1'b0;
      pfirst     <= 1'b0;
      cfg_wr_rej <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      // One-stage issue pipe lines the strobes up with the 1-cycle reads.
      pv         <= issuing;
      pfirst     <= issuing && (idx == '0);
      cfg_wr_rej <= cfg_wr_en && !idle;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_d = S_ISSUE;
          idx_d   = '0;
        end
      end
      S_ISSUE: begin
        if (idx == IDX_LAST) begin
          state_d = S_DRAIN;
          idx_d   = '0;
        end else begin
          idx_d = idx + 1'b1;
        end
      end
      S_DRAIN: state_d = S_RELU;
      S_RELU:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign busy      = !idle;
  assign done      = (state == S_DONE);
  assign dbg_state = state;
  assign in_addr   = issuing ? idx : '0;

  assign lyr.layer_input_index = issuing ? idx : '0;
  assign lyr.layer_input_value = in_data;
  assign lyr.layer_start       = pv & pfirst;
  assign lyr.layer_valid       = pv & ~pfirst;
  assign lyr.layer_relu_en     = (state == S_RELU);

  // Weight memories share their address port with the read path, so writes
  // are only allowed while no pass is running.
  assign lyr.layer_wr_en     = cfg_wr_en & idle;
  assign lyr.layer_wr_row    = cfg_wr_row;
  assign lyr.layer_wr_col    = cfg_wr_col;
  assign lyr.layer_wr_weight = cfg_wr_weight;

endmodule

// File: tb/tb_mlp_layer_ctrl.sv
// Directed bench for mlp_layer_ctrl with a behavioural input buffer and neuron-0 layer model.
module tb_mlp_layer_ctrl;
  import mlp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        go, cfg_wr_en;
  logic [2:0]  cfg_wr_row;
  logic [1:0]  cfg_wr_col;
  logic [15:0] cfg_wr_weight;
  logic        busy, done, cfg_wr_rej;
  logic [1:0]  in_addr;
  logic [15:0] in_data;
  state_t      dbg_state;

  logic        busy1, done1, rej1;
  logic [0:0]  in_addr1;
  logic [15:0] in_data1;
  state_t      dbg1;

  mlp_layer_ctrl_if #(.IDX_W(2), .NR_W(3), .IN_WIDTH(16), .WGT_WIDTH(16)) if0 ();
  mlp_layer_ctrl_if #(.IDX_W(1), .NR_W(3), .IN_WIDTH(16), .WGT_WIDTH(16)) if1 ();

  mlp_layer_ctrl #(.N_INPUTS(4), .N_NEURONS(8), .IN_WIDTH(16), .WGT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .busy(busy), .done(done),
    .in_addr(in_addr), .in_data(in_data),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_row(cfg_wr_row), .cfg_wr_col(cfg_wr_col),
    .cfg_wr_weight(cfg_wr_weight), .cfg_wr_rej(cfg_wr_rej),
    .lyr(if0.master), .dbg_state(dbg_state)
  );

  mlp_layer_ctrl #(.N_INPUTS(1), .N_NEURONS(8), .IN_WIDTH(16), .WGT_WIDTH(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .go(go), .busy(busy1), .done(done1),
    .in_addr(in_addr1), .in_data(in_data1),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_row(cfg_wr_row), .cfg_wr_col(cfg_wr_col[0]),
    .cfg_wr_weight(cfg_wr_weight), .cfg_wr_rej(rej1),
    .lyr(if1.master), .dbg_state(dbg1)
  );

  // ---------------- input buffer and layer model ----------------
  logic signed [15:0] ibuf [4];
  logic signed [15:0] wmem [4];
  logic signed [15:0] w_rd;
  logic signed [39:0] acc, va, wa, prod;
  logic signed [15:0] lout;

  always @(posedge clk) begin
    in_data  <= ibuf[in_addr];
    in_data1 <= ibuf[in_addr1];
  end

  assign va   = if0.layer_input_value;
  assign wa   = w_rd;
  assign prod = va * wa;

  always @(posedge clk) begin
    if (if0.layer_wr_en && if0.layer_wr_row == 3'd0) wmem[if0.layer_wr_col] <= if0.layer_wr_weight;
    w_rd <= wmem[if0.layer_input_index];
    if (if0.layer_start)      acc <= prod;
    else if (if0.layer_valid) acc <= acc + prod;
    if (if0.layer_relu_en) begin
      if (acc < 0)               lout <= 16'sd0;
      else if (acc > 40'sd32767) lout <= 16'sd32767;
      else                       lout <= acc[15:0];
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  logic [31:0] go_m, cfg_m, rst_m;
  logic [31:0] s_m, v_m, r_m, d_m, b_m, we_m, rej_m, s1_m, v1_m, r1_m, d1_m;
  logic [15:0] val_log [32];
  logic [15:0] val1_log [32];
  logic [1:0]  addr_log [32];
  logic [1:0]  idx_log [32];
  state_t      st_log [32];

  // Cycle 0 is the cycle in which go is sampled; inputs for cycle c are driven
  // just after edge c-1 and outputs sampled 1 time unit later.
  task automatic run(input int ncyc);
    s_m = 0; v_m = 0; r_m = 0; d_m = 0; b_m = 0; we_m = 0; rej_m = 0;
    s1_m = 0; v1_m = 0; r1_m = 0; d1_m = 0;
    for (int c = 0; c <= ncyc; c++) begin
      if (c > 0) @(posedge clk);
      #1;
      go        = go_m[c];
      cfg_wr_en = cfg_m[c];
      rst_n     = ~rst_m[c];
      #1;
      s_m[c]   = if0.layer_start;
      v_m[c]   = if0.layer_valid;
      r_m[c]   = if0.layer_relu_en;
      d_m[c]   = done;
      b_m[c]   = busy;
      we_m[c]  = if0.layer_wr_en;
      rej_m[c] = cfg_wr_rej;
      s1_m[c]  = if1.layer_start;
      v1_m[c]  = if1.layer_valid;
      r1_m[c]  = if1.layer_relu_en;
      d1_m[c]  = done1;
      val_log[c]  = if0.layer_input_value;
      val1_log[c] = if1.layer_input_value;
      addr_log[c] = in_addr;
      idx_log[c]  = if0.layer_input_index;
      st_log[c]   = dbg_state;
    end
    go = 1'b0; cfg_wr_en = 1'b0; rst_n = 1'b1;
  endtask

  task automatic wr(input logic [2:0] r, input logic [1:0] c, input logic [15:0] w);
    cfg_wr_row = r; cfg_wr_col = c; cfg_wr_weight = w; cfg_wr_en = 1'b1;
    @(posedge clk); #2;
    cfg_wr_en = 1'b0;
  endtask

  task automatic set_weights(input logic [15:0] w);
    for (int i = 0; i < 4; i++) wr(3'd0, 2'(i), w);
  endtask

  task automatic set_buf(input logic [15:0] a, b, c, d);
    ibuf[0] = a; ibuf[1] = b; ibuf[2] = c; ibuf[3] = d;
  endtask

  // Masks and results of a clean N=4 pass started at cycle 0.
  task automatic chk_pass(input string tag, input logic [15:0] exp_out);
    chk({tag, "_start"}, 64'(s_m & 32'hFF), 64'h04);
    chk({tag, "_valid"}, 64'(v_m & 32'hFF), 64'h38);
    chk({tag, "_relu"},  64'(r_m & 32'hFF), 64'h40);
    chk({tag, "_done"},  64'(d_m & 32'hFF), 64'h80);
    chk({tag, "_out"},   64'(lout), 64'(exp_out));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    go = 0; cfg_wr_en = 0; cfg_wr_row = 0; cfg_wr_col = 0; cfg_wr_weight = 0;
    go_m = 0; cfg_m = 0; rst_m = 0;
    set_buf(16'd1, 16'd2, 16'd3, 16'd4);
    repeat (2) @(posedge clk);
    #2;
    chk("reset_ctrl", 64'({busy, done, cfg_wr_rej, if0.layer_start, if0.layer_valid,
                           if0.layer_relu_en, if0.layer_wr_en}), 64'h0);
    chk("reset_addr", 64'({in_addr, if0.layer_input_index}), 64'h0);
    chk("reset_state", 64'(dbg_state), 64'(S_IDLE));
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Idle write is forwarded unchanged and not rejected.
    cfg_wr_row = 3'd3; cfg_wr_col = 2'd2; cfg_wr_weight = 16'h1234; cfg_wr_en = 1'b1;
    #1;
    chk("fwd_write", 64'({if0.layer_wr_en, if0.layer_wr_row, if0.layer_wr_col, if0.layer_wr_weight}),
        64'({1'b1, 3'd3, 2'd2, 16'h1234}));
    @(posedge clk); #2;
    cfg_wr_en = 1'b0;
    chk("fwd_no_rej", 64'(cfg_wr_rej), 64'h0);

    // Basic pass: {1,2,3,4} . {1,1,1,1} = 10; N=1 instance runs alongside.
    set_weights(16'd1);
    go_m = 32'h1;
    run(8);
    chk_pass("p1", 16'd10);
    chk("p1_busy", 64'(b_m & 32'h1FF), 64'h0FE);
    chk("p1_addr", 64'({addr_log[0], addr_log[1], addr_log[2], addr_log[3], addr_log[4], addr_log[5]}), 64'h06C);
    chk("p1_index", 64'({idx_log[0], idx_log[1], idx_log[2], idx_log[3], idx_log[4], idx_log[5]}), 64'h06C);
    chk("p1_val_start", 64'(val_log[2]), 64'd1);
    chk("p1_val_valid", 64'({val_log[3], val_log[4], val_log[5]}), 64'h0002_0003_0004);
    chk("p1_states", 64'({st_log[1], st_log[5], st_log[6], st_log[7], st_log[8]}),
        64'({S_ISSUE, S_DRAIN, S_RELU, S_DONE, S_IDLE}));
    chk("n1_start", 64'(s1_m & 32'hFF), 64'h04);
    chk("n1_valid", 64'(v1_m & 32'hFF), 64'h00);
    chk("n1_relu",  64'(r1_m & 32'hFF), 64'h08);
    chk("n1_done",  64'(d1_m & 32'hFF), 64'h10);
    chk("n1_val",   64'(val1_log[2]), 64'd1);

    // Negative sum clamps to zero.
    set_weights(16'hFFFF);
    run(8);
    chk_pass("neg", 16'd0);

    // 4 * 10000 = 40000 clips to 32767.
    set_weights(16'd1);
    set_buf(16'd10000, 16'd10000, 16'd10000, 16'd10000);
    run(8);
    chk_pass("clip", 16'd32767);

    // Writes during the pass are dropped and flagged one cycle later;
    // the write coinciding with go in IDLE is forwarded.
    set_buf(16'd1, 16'd2, 16'd3, 16'd4);
    cfg_wr_row = 3'd0; cfg_wr_col = 2'd0; cfg_wr_weight = 16'd7;
    cfg_m = 32'h1D;
    run(8);
    cfg_m = 32'h0;
    chk("rej_wr_en", 64'(we_m & 32'hFF), 64'h01);
    chk("rej_pulse", 64'(rej_m & 32'hFF), 64'h38);
    chk("rej_start", 64'(s_m & 32'hFF), 64'h04);
    // Only the cycle-0 write landed: w0 = 7 -> 7+2+3+4 = 16.
    chk("rej_out", 64'(lout), 64'd16);
    wr(3'd0, 2'd0, 16'd1);

    // go held through the pass is ignored; go at cycle 8 starts a new pass.
    go_m = 32'h1FF;
    run(16);
    go_m = 32'h1;
    chk("rego_done", 64'(d_m), 64'(32'h0000_8080));
    chk("rego_start", 64'(s_m), 64'(32'h0000_0404));
    chk("rego_out", 64'(lout), 64'd10);

    // Reset in cycle 3 aborts the pass; output register keeps its value.
    set_buf(16'd2, 16'd2, 16'd2, 16'd2);
    rst_m = 32'h8;
    run(10);
    rst_m = 32'h0;
    chk("rst_done", 64'(d_m), 64'h0);
    chk("rst_busy", 64'(b_m), 64'h6);
    chk("rst_strobes", 64'(v_m | r_m), 64'h0);
    chk("rst_mid", 64'({addr_log[3], idx_log[3], st_log[3]}), 64'({2'd0, 2'd0, S_IDLE}));
    chk("rst_keep_out", 64'(lout), 64'd10);

    run(8);
    chk_pass("post_rst", 16'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
